// File: rtl/game_timer_pkg.sv
// Shared timing constants and count type for the game-object timer scheduler
// and the game-object FSMs that request its channels.
package game_timer_pkg;

    localparam int GT_NUM_CH   = 4;
    localparam int GT_CNT_W    = 8;
    localparam int GT_TICK_DIV = 500000;

    typedef logic [GT_CNT_W-1:0] count_t;

endpackage

// File: rtl/game_tick_prescaler.sv
// Game-tick prescaler: divides clk by TICK_DIV and emits a registered
// one-cycle tick when the count wraps; pause holds the count and the tick.
module game_tick_prescaler
    import game_timer_pkg::*;
#(
    parameter int TICK_DIV = GT_TICK_DIV
) (
    input  logic clk,
    input  logic resetN,
    input  logic pause,
    output logic tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             wrap;

    assign wrap = (cnt_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (!pause) begin
            tick_d = wrap;
            cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_timer_scheduler.sv
// Multi-channel countdown scheduler: fixed-priority load arbiter plus one
// tick-driven down-counter per channel with a one-cycle expiry pulse.
module game_timer_scheduler
    import game_timer_pkg::*;
#(
    parameter int NUM_CH   = GT_NUM_CH,
    parameter int CNT_W    = GT_CNT_W,
    parameter int TICK_DIV = GT_TICK_DIV
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    pause,
    input  logic [NUM_CH-1:0]       start_req,
    input  logic [NUM_CH*CNT_W-1:0] duration,
    input  logic [NUM_CH-1:0]       cancel,
    output logic [NUM_CH-1:0]       start_gnt,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       expired,
    output logic                    tick
);

    // Handshake: a requester holds start_req[i] until it sees start_gnt[i]=1
    // in the same cycle; the load happens on that edge and the requester
    // drops the request on it. A request still held is granted again.
    logic [NUM_CH-1:0] req_ok;

    game_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .resetN (resetN),
        .pause  (pause),
        .tick   (tick)
    );

    // Lowest set bit of the eligible requests wins; cancelled channels drop out.
    assign req_ok    = start_req & ~cancel;
    assign start_gnt = resetN ? (req_ok & (~req_ok + 1'b1)) : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             busy_q, busy_d;
        logic             exp_q, exp_d;
        logic [CNT_W-1:0] dur_i;

        assign dur_i = duration[i*CNT_W +: CNT_W];

        // Priority: cancel, then load (restart discards the old count and
        // ignores a coincident tick), then the tick-driven decrement.
        always_comb begin
            cnt_d  = cnt_q;
            busy_d = busy_q;
            exp_d  = 1'b0;
            if (cancel[i]) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end else if (start_gnt[i]) begin
                cnt_d  = dur_i;
                busy_d = (dur_i != '0);
                exp_d  = (dur_i == '0);
            end else if (tick && busy_q) begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy_d = 1'b0;
                    exp_d  = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
                exp_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                busy_q <= busy_d;
                exp_q  <= exp_d;
            end
        end

        assign busy[i]    = busy_q;
        assign expired[i] = exp_q;
    end

endmodule

// File: tb/tb_game_timer_scheduler.sv
// Directed bench for game_timer_scheduler with TICK_DIV=4: arbitration,
// countdown/expiry, pause, cancel, restart and reset behaviour.
module tb_game_timer_scheduler;

    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int TICK_DIV = 4;

    logic                    clk;
    logic                    resetN;
    logic                    pause;
    logic [NUM_CH-1:0]       start_req;
    logic [NUM_CH*CNT_W-1:0] duration;
    logic [NUM_CH-1:0]       cancel;
    logic [NUM_CH-1:0]       start_gnt;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       expired;
    logic                    tick;

    int checks;
    int errors;
    int cyc;
    logic [NUM_CH-1:0] exp_seen;

    game_timer_scheduler #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .pause     (pause),
        .start_req (start_req),
        .duration  (duration),
        .cancel    (cancel),
        .start_gnt (start_gnt),
        .busy      (busy),
        .expired   (expired),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Cycle n is the interval just after the n-th rising edge since release.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic set_dur(input int ch, input logic [CNT_W-1:0] val);
        duration[ch*CNT_W +: CNT_W] = val;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        resetN = 1'b0; pause = 1'b0; start_req = '0; cancel = '0; duration = '0;

        // reset state
        step(); step();
        chk("rst_busy", busy, 4'b0000);
        chk("rst_expired", expired, 4'b0000);
        chk("rst_tick", tick, 1'b0);
        start_req = 4'b0001; #1;
        chk("rst_gnt", start_gnt, 4'b0000);
        start_req = '0;
        resetN = 1'b1; cyc = 0;

        // single countdown on ch2, duration 3
        set_dur(2, 3); start_req = 4'b0100; #1;
        chk("t1_gnt", start_gnt, 4'b0100);
        step(); start_req = '0;
        chk("t1_busy", busy, 4'b0100);
        step_to(4);  chk("t1_tick_first", tick, 1'b1);
        step();      chk("t1_tick_pulse", tick, 1'b0);
        step_to(12); chk("t1_busy_late", busy, 4'b0100);
        chk("t1_no_early_exp", expired, 4'b0000);
        step();      chk("t1_expired", expired, 4'b0100);
        chk("t1_busy_clear", busy, 4'b0000);
        step();      chk("t1_exp_once", expired, 4'b0000);

        // priority order for 1011, requesters drop after grant
        set_dur(0, 10); set_dur(1, 10); set_dur(3, 10);
        start_req = 4'b1011; #1;
        chk("t2_gnt0", start_gnt, 4'b0001);
        step(); start_req = 4'b1010; #1;
        chk("t2_gnt1", start_gnt, 4'b0010);
        step(); start_req = 4'b1000; #1;
        chk("t2_gnt3", start_gnt, 4'b1000);
        step(); start_req = '0;
        chk("t2_busy", busy, 4'b1011);
        cancel = 4'b1011;
        step(); cancel = '0;
        chk("t2_cancel_busy", busy, 4'b0000);
        chk("t2_cancel_noexp", expired, 4'b0000);
        start_req = 4'b0011; cancel = 4'b0001; #1;
        chk("t2_cancel_pass", start_gnt, 4'b0010);
        step(); start_req = '0; cancel = '0;
        chk("t2_pass_busy", busy, 4'b0010);
        cancel = 4'b0010;
        step(); cancel = '0;
        chk("t2_idle", busy, 4'b0000);

        // zero duration on ch3 (cycle 20)
        set_dur(3, 0); start_req = 4'b1000; #1;
        chk("t3_gnt", start_gnt, 4'b1000);
        step(); start_req = '0;
        chk("t3_expired", expired, 4'b1000);
        chk("t3_busy", busy, 4'b0000);
        step(); chk("t3_exp_once", expired, 4'b0000);

        // cancel in the expiry-tick cycle on ch0 (cycle 22)
        set_dur(0, 2); start_req = 4'b0001; #1;
        chk("t4_gnt", start_gnt, 4'b0001);
        step(); start_req = '0;
        chk("t4_busy", busy, 4'b0001);
        step_to(27); chk("t4_busy_mid", busy, 4'b0001);
        step();      chk("t4_tick", tick, 1'b1);
        cancel = 4'b0001;
        step(); cancel = '0;
        chk("t4_noexp", expired, 4'b0000);
        chk("t4_busy_clear", busy, 4'b0000);
        step(); chk("t4_noexp_late", expired, 4'b0000);

        // ch1 with 5, pause for 20 clocks: expiry moves from cycle 49 to 69
        set_dur(1, 5); start_req = 4'b0010; #1;
        chk("t5_gnt", start_gnt, 4'b0010);
        step(); start_req = '0;
        chk("t5_busy", busy, 4'b0010);
        step_to(34); pause = 1'b1;
        for (int k = 35; k <= 40; k++) begin
            step(); chk("t5_tick_paused", tick, 1'b0);
        end
        set_dur(3, 0); start_req = 4'b1000; #1;
        chk("t5_gnt_paused", start_gnt, 4'b1000);
        step(); start_req = '0;
        chk("t5_zero_exp_paused", expired, 4'b1000);
        for (int k = 42; k <= 54; k++) begin
            step(); chk("t5_tick_paused", tick, 1'b0);
        end
        pause = 1'b0;
        chk("t5_busy_frozen", busy, 4'b0010);
        step_to(56); chk("t5_tick_resume", tick, 1'b1);
        step_to(68); chk("t5_no_early_exp", expired, 4'b0000);
        chk("t5_busy_late", busy, 4'b0010);
        step();      chk("t5_expired", expired, 4'b0010);
        chk("t5_busy_clear", busy, 4'b0000);
        step();      chk("t5_exp_once", expired, 4'b0000);

        // restart of ch0 on a tick cycle, and ch2 expiring in the same cycle
        set_dur(0, 2); start_req = 4'b0001; #1;
        chk("t6_gnt", start_gnt, 4'b0001);
        step(); start_req = '0;
        step_to(76); chk("t6_tick", tick, 1'b1);
        set_dur(0, 3); start_req = 4'b0001; #1;
        chk("t6_regnt", start_gnt, 4'b0001);
        step(); start_req = '0;
        chk("t6_restart_noexp", expired, 4'b0000);
        chk("t6_restart_busy", busy, 4'b0001);
        set_dur(2, 3); start_req = 4'b0100; #1;
        chk("t6_gnt2", start_gnt, 4'b0100);
        step(); start_req = '0;
        chk("t6_busy_both", busy, 4'b0101);
        step_to(85); chk("t6_no_early_exp", expired, 4'b0000);
        step_to(88); chk("t6_busy_late", busy, 4'b0101);
        step();      chk("t6_expired_both", expired, 4'b0101);
        chk("t6_busy_clear", busy, 4'b0000);
        step();      chk("t6_exp_once", expired, 4'b0000);

        // reset while ch0 holds count 7 (cycle 90)
        set_dur(0, 7); start_req = 4'b0001; #1;
        chk("t7_gnt", start_gnt, 4'b0001);
        step(); start_req = '0;
        chk("t7_busy", busy, 4'b0001);
        step_to(92); chk("t7_tick_pre", tick, 1'b1);
        resetN = 1'b0; #1;
        chk("t7_rst_tick", tick, 1'b0);
        chk("t7_rst_busy", busy, 4'b0000);
        chk("t7_rst_expired", expired, 4'b0000);
        start_req = 4'b0001; #1;
        chk("t7_rst_gnt", start_gnt, 4'b0000);
        start_req = '0;
        step(); step();
        resetN = 1'b1; cyc = 0;
        for (int k = 1; k <= 3; k++) begin
            step(); chk("t7_tick_early", tick, 1'b0);
        end
        step(); chk("t7_tick_first", tick, 1'b1);
        exp_seen = '0;
        for (int k = 5; k <= 40; k++) begin
            step(); exp_seen |= expired;
        end
        chk("t7_no_exp_after", exp_seen, 4'b0000);
        chk("t7_busy_after", busy, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_timer_scheduler.md
GAME_TIMER_SCHEDULER -- requirements
Module: game_timer_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent countdown channels shared by game objects (fruit drop, enemy spawn, level clock, death delay).
REQ-002 Parameter CNT_W, default 8, width of a channel count in ticks.
REQ-003 Parameter TICK_DIV, default 500000, clocks per game tick (50 Hz at 25 MHz).
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 pause  in  1  level; freezes tick generation while high.
REQ-007 start_req  in  NUM_CH  level per channel; request to load that channel's duration.
REQ-008 duration  in  NUM_CH*CNT_W  flattened load values; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-009 cancel  in  NUM_CH  level per channel; abort channel without expiry.
REQ-010 start_gnt  out  NUM_CH  one-hot or zero, combinational; the channel loaded at the coming edge.
REQ-011 busy  out  NUM_CH  registered; channel counting.
REQ-012 expired  out  NUM_CH  registered one-cycle pulse per completed countdown.
REQ-013 tick  out  1  registered one-cycle game-tick pulse.

Function
REQ-014 Prescaler counts 0..TICK_DIV-1 and wraps; tick is high for the one cycle after the edge where the count reaches TICK_DIV-1; while pause=1 the prescaler holds and tick stays 0.
REQ-015 Arbitration: at most one grant per clock; the lowest-index channel with start_req=1 and cancel=0 wins; start_gnt depends only on the current-cycle start_req and cancel.
REQ-016 Requester holds start_req until it samples start_gnt=1, then deasserts it on that edge; a still-held request is granted again.
REQ-017 A granted channel loads duration[i] at the edge; if duration>0, busy[i]=1 from the next cycle.
REQ-018 A grant to a busy channel restarts it with the new duration; no expired pulse occurs for the aborted count.
REQ-019 duration=0: busy[i] stays 0 and expired[i] pulses in the cycle after the grant.
REQ-020 On each tick, every busy channel not being loaded or cancelled decrements by 1.
REQ-021 A decrement from 1 to 0 clears busy[i] and raises expired[i] for exactly one cycle; there is no further pulse until the channel is reloaded.
REQ-022 When a load and a tick coincide on the same channel, the load wins and that tick is ignored for that channel.
REQ-023 cancel[i]=1 clears count and busy at the edge, suppresses expired[i] even if expiry coincides, and suppresses the grant to channel i; arbitration passes to the next requester.
REQ-024 While pause=1, grants, loads, cancels and duration-0 expiries still operate; countdowns freeze.
REQ-025 Channels are fully independent; multiple expired bits may pulse in the same cycle.

Reset
REQ-026 On resetN=0, the prescaler, all counts, busy, expired and tick are cleared to 0 immediately.
REQ-027 start_gnt is 0 during reset.
REQ-028 Reset mid-countdown discards the count with no expired pulse; after release, the first tick occurs TICK_DIV clocks later.

Structure
REQ-029 Package game_timer_pkg holds NUM_CH, CNT_W, TICK_DIV defaults and the count typedef, shared with game-object FSMs.
REQ-030 Prescaler is the sub-module game_tick_prescaler (inputs clk, resetN, pause; output tick).
REQ-031 Arbiter and per-channel counters are generated inside game_timer_scheduler; no other sub-modules.

Verification (TICK_DIV=4, CNT_W=8)
REQ-032 start_req[2]=1 with duration=3 -> start_gnt[2] in the same cycle; busy[2] for 3 ticks; expired[2] a single pulse on the cycle after the 3rd tick edge; busy[2]=0 after.
REQ-033 start_req=4'b1011 held -> grants in the order ch0, ch1, ch3 on consecutive cycles (requesters drop after grant).
REQ-034 ch1 loaded with 5; pause held for 20 clocks mid-count -> no tick, count frozen; expiry is delayed by exactly 20 clocks versus the unpaused run.
REQ-035 ch0 loaded with 2; cancel[0] pulsed in the expiry-tick cycle -> no expired[0]; busy[0]=0.
REQ-036 duration=0 on ch3 -> expired[3] pulse one cycle after the grant; busy[3] never set.
REQ-037 resetN asserted while ch0 busy with count 7 -> outputs 0 immediately; no expired pulse after release; first tick 4 clocks after release.
